// File: rtl/switch_instr_latch_pkg.sv
// rtl/switch_instr_latch_pkg.sv - FSM encodings and debounce default for the TinyCPU switch input stage
package switch_instr_latch_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam int DB_CYCLES_DEFAULT = 1000000;

endpackage

// File: rtl/switch_instr_latch_debounce.sv
// rtl/switch_instr_latch_debounce.sv - 2-flop synchronizer plus saturating-counter debouncer
module switch_instr_latch_debounce
  import switch_instr_latch_pkg::*;
#(
  parameter int WIDTH     = 1,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // stable follows cand whenever the count has saturated, even on the edge a new mismatch restarts it
  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (cnt_q == CNT_MAX) begin
      stable_d = cand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/switch_instr_latch.sv
// rtl/switch_instr_latch.sv - debounced instruction latch with run/hold/single-step control
module switch_instr_latch
  import switch_instr_latch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int CNT_W     = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw,
  input  logic       pause,
  input  logic       step_btn,
  output logic [7:0] instr,
  output logic       instr_valid,
  output logic       held
);

  logic [7:0] sw_stable;
  logic       pause_stable;
  logic       step_stable;

  switch_instr_latch_debounce #(.WIDTH(8), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_sw (
    .clk(clk), .rst(rst), .din(sw), .dout(sw_stable)
  );

  switch_instr_latch_debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_pause (
    .clk(clk), .rst(rst), .din(pause), .dout(pause_stable)
  );

  switch_instr_latch_debounce #(.WIDTH(1), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_step (
    .clk(clk), .rst(rst), .din(step_btn), .dout(step_stable)
  );

  state_e     state_q, state_d;
  logic       step_prev_q;
  logic       step_rise;
  logic [7:0] instr_q, instr_d;
  logic       instr_valid_q, instr_valid_d;
  logic       held_q, held_d;

  assign step_rise = step_stable & ~step_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      step_prev_q   <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      step_prev_q   <= step_stable;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      held_q        <= held_d;
    end
  end

  // un-pausing wins over a simultaneous step press; that press is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (pause_stable) state_d = ST_HOLD;
      ST_HOLD: begin
        if (!pause_stable)  state_d = ST_RUN;
        else if (step_rise) state_d = ST_STEP;
      end
      ST_STEP: state_d = ST_HOLD;
      default: state_d = ST_RUN;
    endcase
  end

  // outputs are decoded from the next state so they line up with the registered state
  always_comb begin
    instr_valid_d = (state_d == ST_RUN) || (state_d == ST_STEP);
    held_d        = (state_d == ST_HOLD) || (state_d == ST_STEP);
    instr_d       = instr_valid_d ? sw_stable : instr_q;
  end

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign held        = held_q;

endmodule

// File: tb/tb_switch_instr_latch.sv
// tb/tb_switch_instr_latch.sv - self-checking bench for switch_instr_latch
module tb_switch_instr_latch;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] sw = 8'h00;
  logic       pause = 1'b0;
  logic       step_btn = 1'b0;
  logic [7:0] instr;
  logic       instr_valid;
  logic       held;

  int errors = 0;
  int checks = 0;

  switch_instr_latch #(.DB_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .sw(sw), .pause(pause), .step_btn(step_btn),
    .instr(instr), .instr_valid(instr_valid), .held(held)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an input's debounced value takes the synchronized sample
  // once that sample has been identical for the last DB edges since reset.
  localparam int M_RUN = 0, M_HOLD = 1, M_STEP = 2;
  logic [9:0] hist[$];
  logic [9:0] dly[$];
  logic [9:0] stab;
  logic       m_prev;
  int         m_mode;
  logic [7:0] m_instr;
  logic       m_valid, m_held;

  function automatic logic [9:0] settle(input logic [9:0] cur, input logic [9:0] mask);
    logic [9:0] last;
    last = hist[DB-1] & mask;
    for (int i = 0; i < DB; i++)
      if ((hist[i] & mask) != last) return cur;
    return (cur & ~mask) | last;
  endfunction

  task automatic model_edge(input logic r, input logic [9:0] raw);
    logic rise;
    if (r) begin
      hist    = '{10'h000};
      dly     = '{10'h000, 10'h000};
      stab    = '0;
      m_prev  = 1'b0;
      m_mode  = M_RUN;
      m_instr = 8'h00;
      m_valid = 1'b0;
      m_held  = 1'b0;
    end else begin
      rise   = stab[0] & ~m_prev;
      m_prev = stab[0];
      case (m_mode)
        M_RUN:   if (stab[1]) m_mode = M_HOLD;
        M_HOLD:  if (!stab[1]) m_mode = M_RUN; else if (rise) m_mode = M_STEP;
        default: m_mode = M_HOLD;
      endcase
      if (m_mode != M_HOLD) m_instr = stab[9:2];
      m_valid = (m_mode != M_HOLD);
      m_held  = (m_mode != M_RUN);
      if (hist.size() == DB) begin
        stab = settle(stab, 10'h3FC);
        stab = settle(stab, 10'h002);
        stab = settle(stab, 10'h001);
      end
      hist.push_back(dly.pop_front());
      dly.push_back(raw);
      if (hist.size() > DB) void'(hist.pop_front());
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge(rst, {sw, pause, step_btn});
      #1;
      check("model_instr", {24'h0, instr}, {24'h0, m_instr});
      check("model_valid", {31'h0, instr_valid}, {31'h0, m_valid});
      check("model_held", {31'h0, held}, {31'h0, m_held});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int n;
    int bad;
    int found;
    logic [7:0] cap;

    // reset then run
    cyc(2);
    rst = 1'b0; sw = 8'hA5;
    cyc(1);
    check("post_reset_instr", {24'h0, instr}, 32'h00);
    check("post_reset_valid", {31'h0, instr_valid}, 32'h1);
    check("post_reset_held", {31'h0, held}, 32'h0);
    cyc(6);
    check("a5_edge7", {24'h0, instr}, 32'h00);
    cyc(1);
    check("a5_edge8", {24'h0, instr}, 32'hA5);

    // glitch reject, then a 4-cycle pulse that does propagate
    sw = 8'h3C; cyc(10);
    check("run_3c", {24'h0, instr}, 32'h3C);
    sw = 8'hFF; cyc(3); sw = 8'h3C;
    bad = 0;
    for (int i = 0; i < 12; i++) begin cyc(1); if (instr !== 8'h3C) bad++; end
    check("glitch3_reject", bad, 0);
    sw = 8'hFF; cyc(4); sw = 8'h3C;
    n = 0;
    for (int i = 0; i < 14; i++) begin cyc(1); if (instr === 8'hFF) n++; end
    check("pulse4_cycles", n, 4);

    // pause hold
    sw = 8'h11; cyc(10);
    pause = 1'b1; cyc(7);
    check("hold_edge7", {31'h0, held}, 32'h0);
    cyc(1);
    check("hold_edge8_held", {31'h0, held}, 32'h1);
    check("hold_edge8_valid", {31'h0, instr_valid}, 32'h0);
    sw = 8'h22; cyc(20);
    check("hold_frozen", {24'h0, instr}, 32'h11);

    // single step, two presses
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin sw = 8'h33; cyc(10); end
      step_btn = 1'b1; n = 0; cap = 8'h00;
      for (int i = 0; i < 25; i++) begin
        cyc(1);
        if (i == 9) step_btn = 1'b0;
        if (instr_valid) begin n++; cap = instr; end
      end
      check("step_pulses", n, 1);
      check("step_instr", {24'h0, cap}, (p == 0) ? 32'h22 : 32'h33);
    end

    // pause release coincides with a step press: no STEP cycle
    pause = 1'b0; step_btn = 1'b1; n = 0;
    for (int i = 0; i < 20; i++) begin cyc(1); if (instr_valid && held) n++; end
    check("simul_no_step", n, 0);
    check("simul_run_valid", {31'h0, instr_valid}, 32'h1);
    check("simul_run_instr", {24'h0, instr}, 32'h33);
    step_btn = 1'b0; cyc(10);

    // reset during STEP
    pause = 1'b1; cyc(12);
    check("pre_step_hold", {31'h0, held}, 32'h1);
    step_btn = 1'b1; found = 0;
    for (int i = 0; i < 30 && found == 0; i++) begin
      cyc(1);
      if (instr_valid && held) found = 1;
    end
    check("step_reached", found, 1);
    rst = 1'b1; step_btn = 1'b0; pause = 1'b0;
    cyc(1);
    check("rst_step_instr", {24'h0, instr}, 32'h00);
    check("rst_step_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_step_held", {31'h0, held}, 32'h0);
    rst = 1'b0; cyc(1);
    check("rerun_valid", {31'h0, instr_valid}, 32'h1);
    check("rerun_held", {31'h0, held}, 32'h0);
    cyc(10);

    // reset during a debounce count restarts it
    sw = 8'h55; cyc(4);
    rst = 1'b1; cyc(1); rst = 1'b0;
    cyc(7);
    check("restart_edge7", {24'h0, instr}, 32'h00);
    cyc(1);
    check("restart_edge8", {24'h0, instr}, 32'h55);

    // randomized phase, checked by the model every cycle
    for (int s = 0; s < 600; s++) begin
      if ($urandom_range(0, 2) == 0) sw = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) pause = ~pause;
      if ($urandom_range(0, 2) == 0) step_btn = ~step_btn;
      rst = ($urandom_range(0, 59) == 0);
      cyc($urandom_range(1, 8));
      rst = 1'b0;
    end
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
